key_pos_decoder: RTL and testbench
==================================

KEY_POS_DECODER -- requirements
Module: key_pos_decoder

Interface
REQ-001 Parameter COOLDOWN, default 24'd1_000_000, minimum cycles between two accepted hits (10 ms at 100 MHz); legal range 1..2^24-1.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-004 key_valid  input  1  one-cycle strobe from the PS/2 receiver; a new key event is present.
REQ-005 key_code  input  9  scan code qualified by key_valid; bit 8 = E0 extended flag, bits 7:0 = scan code.
REQ-006 key_break  input  1  qualified by key_valid; 1 = release (F0) event, 0 = make event.
REQ-007 one_pulse_pos  output  4  hole number 1..9 for exactly one cycle on an accepted hit, else 4'd0.
REQ-008 hit  output  1  high in exactly the cycle one_pulse_pos is nonzero.
REQ-009 held_mask  output  9  bit (p-1) set while hole key p is physically held.
REQ-010 hit_count  output  8  accepted hits since reset, saturating at 8'd255.
REQ-011 drop_count  output  8  makes rejected by cooldown since reset, saturating at 8'd255.

Function
REQ-012 Mapping (non-extended only): numpad 0x69,0x72,0x7A,0x6B,0x73,0x74,0x6C,0x75,0x7D and top-row 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to holes 1..9 in that order.
REQ-013 Any code with bit 8 set, or not in REQ-012, is ignored: no output, no state change.
REQ-014 Both keys for one hole share one held_mask bit; make of either sets it, break of either clears it.
REQ-015 Mapped make with held_mask bit already set (typematic repeat) is ignored: no pulse, no drop count.
REQ-016 Mapped make with bit clear sets the bit in the next cycle, always, including during cooldown.
REQ-017 Two states: READY, COOL; reset enters READY.
REQ-018 READY + new mapped make (REQ-016): registered outputs one_pulse_pos=p, hit=1 in the cycle after key_valid (latency 1); hit_count increments; state -> COOL; cooldown counter loads COOLDOWN-1.
REQ-019 COOL: counter decrements each cycle; at 0, next cycle is READY; counter width 24 bits, no wrap.
REQ-020 COOL + new mapped make: no pulse; drop_count increments (saturating); counter not reloaded.
REQ-021 key_valid in the last COOL cycle (counter=0) is treated as COOL (dropped); first accepted event is one arriving in READY.
REQ-022 COOLDOWN=1: COOL lasts exactly one cycle; two makes one cycle apart on different holes -> second dropped; makes two cycles apart -> both accepted.
REQ-023 Break events never pulse, never count, never affect state/counter; break of an unheld hole is a no-op.
REQ-024 one_pulse_pos and hit return to 0 the cycle after a pulse; never high two consecutive cycles.
REQ-025 Counters saturate: increment at 255 leaves 255.

Reset
REQ-026 While rst=0: one_pulse_pos=0, hit=0, held_mask=0, hit_count=0, drop_count=0, state=READY, cooldown counter=0.
REQ-027 Reset mid-COOL or with keys held discards all state; after release, first mapped make is accepted and pulses.
REQ-028 key_valid coincident with rst=0 is lost; key_valid in first cycle after rst rises is processed normally.

Verification
REQ-029 READY, key_valid, code 0x073, make -> next cycle one_pulse_pos=5, hit=1, held_mask=9'b000010000, hit_count=1; following cycle pos=0, hit=0.
REQ-030 Make 0x069 then 3 repeats of 0x069 (held), COOLDOWN=4 elapsed -> exactly one pulse (pos=1), drop_count=0; break 0x069 -> held_mask=0.
REQ-031 COOLDOWN=4: make 0x16 at t, make 0x1E at t+2 -> pulse pos=1 only, drop_count=1, held_mask bits 0,1 set; make 0x26 at t+6 -> pulse pos=3.
REQ-032 Make 0x173 (extended) and make 0x1C (unmapped) -> no pulse, held_mask, counters unchanged.
REQ-033 Hold 0x7D, enter COOL, assert rst=0 asynchronously mid-cycle -> outputs/counters 0 immediately; rst=1, make 0x7D -> pos=9 pulse.
REQ-034 COOLDOWN=1, 300 accepted hits on alternating holes with release -> hit_count=255 saturated.

Source files
------------

// File: rtl/key_pos_decoder.sv
// key_pos_decoder: maps PS/2 make/break events on numpad or top-row digit
// keys to golf-hole positions 1..9, emits a one-cycle hit pulse per accepted
// press, and rate-limits accepted hits with a cooldown window.
module key_pos_decoder #(
   parameter logic [23:0] COOLDOWN = 24'd1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [8:0] key_code,
   input  logic       key_break,
   output logic [3:0] one_pulse_pos,
   output logic       hit,
   output logic [8:0] held_mask,
   output logic [7:0] hit_count,
   output logic [7:0] drop_count
);

   localparam int unsigned HOLES   = 9;
   localparam int unsigned POS_W   = 4;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned COOL_W  = 24;

   typedef enum logic {
      ST_READY = 1'b0,
      ST_COOL  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [COOL_W-1:0]   cool_q, cool_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                hit_q, hit_d;
   logic [HOLES-1:0]    held_q, held_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

   logic [POS_W-1:0]    hole_c;
   logic [HOLES-1:0]    hole_mask_c;
   logic                new_make_c;
   logic                break_ev_c;

   // Scan-code to hole decode; extended codes never map
   always_comb begin
      hole_c = POS_W'(0);
      if (!key_code[8]) begin
         unique case (key_code[7:0])
            8'h69, 8'h16: hole_c = POS_W'(1);
            8'h72, 8'h1E: hole_c = POS_W'(2);
            8'h7A, 8'h26: hole_c = POS_W'(3);
            8'h6B, 8'h25: hole_c = POS_W'(4);
            8'h73, 8'h2E: hole_c = POS_W'(5);
            8'h74, 8'h36: hole_c = POS_W'(6);
            8'h6C, 8'h3D: hole_c = POS_W'(7);
            8'h75, 8'h3E: hole_c = POS_W'(8);
            8'h7D, 8'h46: hole_c = POS_W'(9);
            default:      hole_c = POS_W'(0);
         endcase
      end
   end

   // One-hot held-mask bit for the decoded hole (zero when unmapped)
   always_comb begin
      hole_mask_c = '0;
      if (hole_c != POS_W'(0)) begin
         hole_mask_c = HOLES'(1) << (hole_c - POS_W'(1));
      end
   end

   // A press only counts if the hole is not already held (typematic filter)
   assign new_make_c = key_valid && !key_break && (hole_mask_c != '0) &&
                       ((held_q & hole_mask_c) == '0);
   assign break_ev_c = key_valid && key_break && (hole_mask_c != '0);

   // Next-state, pulse, counters and held tracking
   always_comb begin
      state_d    = state_q;
      cool_d     = cool_q;
      pos_d      = POS_W'(0);
      hit_d      = 1'b0;
      held_d     = held_q;
      hit_cnt_d  = hit_cnt_q;
      drop_cnt_d = drop_cnt_q;

      if (new_make_c) begin
         held_d = held_q | hole_mask_c;
      end else if (break_ev_c) begin
         held_d = held_q & ~hole_mask_c;
      end

      unique case (state_q)
         ST_READY: begin
            if (new_make_c) begin
               pos_d   = hole_c;
               hit_d   = 1'b1;
               state_d = ST_COOL;
               cool_d  = COOLDOWN - COOL_W'(1);
               if (hit_cnt_q != {CNT_W{1'b1}}) begin
                  hit_cnt_d = hit_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_COOL: begin
            if (new_make_c && (drop_cnt_q != {CNT_W{1'b1}})) begin
               drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
            if (cool_q == COOL_W'(0)) begin
               state_d = ST_READY;
            end else begin
               cool_d = cool_q - COOL_W'(1);
            end
         end
         default: begin
            state_d = ST_READY;
            cool_d  = COOL_W'(0);
         end
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_READY;
         cool_q     <= COOL_W'(0);
         pos_q      <= POS_W'(0);
         hit_q      <= 1'b0;
         held_q     <= '0;
         hit_cnt_q  <= CNT_W'(0);
         drop_cnt_q <= CNT_W'(0);
      end else begin
         state_q    <= state_d;
         cool_q     <= cool_d;
         pos_q      <= pos_d;
         hit_q      <= hit_d;
         held_q     <= held_d;
         hit_cnt_q  <= hit_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign one_pulse_pos = pos_q;
   assign hit           = hit_q;
   assign held_mask     = held_q;
   assign hit_count     = hit_cnt_q;
   assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_key_pos_decoder.sv
// Bench for key_pos_decoder: two instances (cooldown 4 and cooldown 1) share
// the same stimulus; an event-level model tracks each and is compared every
// cycle, with literal expectations pinning key scenarios.
module tb_key_pos_decoder;

   logic       clk;
   logic       rst;
   logic       key_valid;
   logic [8:0] key_code;
   logic       key_break;

   logic [3:0] pos4, pos1;
   logic       hit4, hit1;
   logic [8:0] held4, held1;
   logic [7:0] hc4, hc1, dc4, dc1;

   int n_checks = 0;
   int n_errors = 0;

   key_pos_decoder #(.COOLDOWN(24'd4)) u_dut4 (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_break(key_break), .one_pulse_pos(pos4), .hit(hit4),
      .held_mask(held4), .hit_count(hc4), .drop_count(dc4)
   );

   key_pos_decoder #(.COOLDOWN(24'd1)) u_dut1 (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_break(key_break), .one_pulse_pos(pos1), .hit(hit1),
      .held_mask(held1), .hit_count(hc1), .drop_count(dc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [7:0] codes [18] = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D,
                              8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   longint     cool_len [2] = '{4, 1};
   int         m_pos   [2];
   logic [8:0] m_held  [2];
   int         m_hits  [2];
   int         m_drops [2];
   longint     m_last  [2];
   bit         m_have  [2];
   longint     cyc;

   function automatic int map_code(input logic [8:0] c);
      if (c[8]) return 0;
      for (int i = 0; i < 18; i++) begin
         if (codes[i] == c[7:0]) return (i % 9) + 1;
      end
      return 0;
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
         m_pos[d] = 0; m_held[d] = '0; m_hits[d] = 0; m_drops[d] = 0;
         m_last[d] = 0; m_have[d] = 1'b0;
      end
   endtask

   // Accepted press needs strictly more than COOLDOWN cycles since last acceptance
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            model_reset();
         end else begin
            int p;
            cyc++;
            p = map_code(key_code);
            for (int d = 0; d < 2; d++) begin
               m_pos[d] = 0;
               if (key_valid && p != 0) begin
                  if (key_break) begin
                     m_held[d][p-1] = 1'b0;
                  end else if (!m_held[d][p-1]) begin
                     m_held[d][p-1] = 1'b1;
                     if (!m_have[d] || (cyc - m_last[d]) > cool_len[d]) begin
                        m_pos[d] = p;
                        m_last[d] = cyc;
                        m_have[d] = 1'b1;
                        if (m_hits[d] < 255) m_hits[d]++;
                     end else if (m_drops[d] < 255) begin
                        m_drops[d]++;
                     end
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of both instances against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("d4.pos",   int'(pos4),  m_pos[0]);
         chk("d4.hit",   int'(hit4),  int'(m_pos[0] != 0));
         chk("d4.held",  int'(held4), int'(m_held[0]));
         chk("d4.hits",  int'(hc4),   m_hits[0]);
         chk("d4.drops", int'(dc4),   m_drops[0]);
         chk("d1.pos",   int'(pos1),  m_pos[1]);
         chk("d1.hit",   int'(hit1),  int'(m_pos[1] != 0));
         chk("d1.held",  int'(held1), int'(m_held[1]));
         chk("d1.hits",  int'(hc1),   m_hits[1]);
         chk("d1.drops", int'(dc1),   m_drops[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [8:0] code, input logic brk);
      key_valid = 1'b1;
      key_code  = code;
      key_break = brk;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 9'h000;
      key_break = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; key_valid = 1'b0; key_code = 9'h000; key_break = 1'b0;
      idle(2);
      chk("rst.pos",   int'(pos4),  0);
      chk("rst.hit",   int'(hit4),  0);
      chk("rst.held",  int'(held4), 0);
      chk("rst.hits",  int'(hc4),   0);
      chk("rst.drops", int'(dc4),   0);

      // Event during reset is lost
      send(9'h069, 1'b0);
      chk("rst.lost_held", int'(held4), 0);
      rst = 1'b1;

      // Single make on hole 5, first cycle after reset release
      send(9'h073, 1'b0);
      chk("h5.pos",  int'(pos4),  5);
      chk("h5.hit",  int'(hit4),  1);
      chk("h5.held", int'(held4), 9'b000010000);
      chk("h5.hits", int'(hc4),   1);
      idle(1);
      chk("h5.pos_clr", int'(pos4), 0);
      chk("h5.hit_clr", int'(hit4), 0);
      send(9'h073, 1'b1);
      chk("h5.brk", int'(held4), 0);
      idle(6);

      // Typematic repeats are ignored
      send(9'h069, 1'b0);
      chk("rep.pos", int'(pos4), 1);
      send(9'h069, 1'b0);
      send(9'h069, 1'b0);
      send(9'h069, 1'b0);
      idle(6);
      chk("rep.hits",  int'(hc4), 2);
      chk("rep.drops", int'(dc4), 0);
      send(9'h069, 1'b1);
      chk("rep.brk", int'(held4), 0);
      idle(6);

      // Cooldown drop, then acceptance after window
      send(9'h016, 1'b0);
      chk("cd.pos1", int'(pos4), 1);
      idle(1);
      send(9'h01E, 1'b0);
      chk("cd.hit_drop", int'(hit4),  0);
      chk("cd.drops",    int'(dc4),   1);
      chk("cd.held",     int'(held4), 9'b000000011);
      idle(3);
      send(9'h026, 1'b0);
      chk("cd.pos3", int'(pos4), 3);
      send(9'h016, 1'b1);
      send(9'h01E, 1'b1);
      send(9'h026, 1'b1);
      idle(6);

      // Extended and unmapped codes are ignored
      send(9'h173, 1'b0);
      chk("ext.hit", int'(hit4), 0);
      send(9'h01C, 1'b0);
      chk("unm.hit",   int'(hit4),  0);
      chk("unm.held",  int'(held4), 0);
      chk("unm.hits",  int'(hc4),   4);
      chk("unm.drops", int'(dc4),   1);
      idle(6);

      // Asynchronous reset mid-cooldown with a key held
      send(9'h07D, 1'b0);
      chk("ar.pos", int'(pos4), 9);
      #2 rst = 1'b0;
      #1;
      chk("ar.pos0",   int'(pos4),  0);
      chk("ar.held0",  int'(held4), 0);
      chk("ar.hits0",  int'(hc4),   0);
      chk("ar.drops0", int'(dc4),   0);
      @(negedge clk);
      rst = 1'b1;
      send(9'h07D, 1'b0);
      chk("ar.pos9", int'(pos4), 9);
      chk("ar.hits", int'(hc4),  1);
      send(9'h07D, 1'b1);
      idle(6);

      // Cooldown of one: adjacent drop, two-apart accept
      send(9'h016, 1'b0);
      chk("c1.a", int'(pos1), 1);
      send(9'h01E, 1'b0);
      chk("c1.b_drop", int'(hit1), 0);
      send(9'h026, 1'b0);
      chk("c1.c", int'(pos1), 3);
      send(9'h016, 1'b1);
      send(9'h01E, 1'b1);
      send(9'h026, 1'b1);
      idle(3);

      // Hit counter saturation on the cooldown-one instance
      for (int i = 0; i < 300; i++) begin
         logic [8:0] c;
         c = (i % 2 == 0) ? 9'h069 : 9'h072;
         send(c, 1'b0);
         send(c, 1'b1);
      end
      idle(2);
      chk("sat.hits", int'(hc1), 255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
